// File: rtl/x86_regs_pkg.sv
// ---------------------------------------------------------------------------
// x86_regs_pkg
// Shared definitions for the writeback end of the pipeline:
//   - sizing constants (result width, register count, RIP width, queue depth)
//   - architectural register codes REG_RAX .. REG_R15 in x86 encoding order
//   - wb_entry_t : one buffered Execute result as it waits to retire
//   - wb_state_t : retirement state (RUN, DRAIN after a kill is accepted, HALT)
// ---------------------------------------------------------------------------
package x86_regs_pkg;

    localparam int DATA_W = 64;
    localparam int NREG   = 16;
    localparam int REG_W  = 4;
    localparam int RIP_W  = 32;
    localparam int QDEPTH = 2;

    localparam logic [REG_W-1:0] REG_RAX = 4'd0;
    localparam logic [REG_W-1:0] REG_RCX = 4'd1;
    localparam logic [REG_W-1:0] REG_RDX = 4'd2;
    localparam logic [REG_W-1:0] REG_RBX = 4'd3;
    localparam logic [REG_W-1:0] REG_RSP = 4'd4;
    localparam logic [REG_W-1:0] REG_RBP = 4'd5;
    localparam logic [REG_W-1:0] REG_RSI = 4'd6;
    localparam logic [REG_W-1:0] REG_RDI = 4'd7;
    localparam logic [REG_W-1:0] REG_R8  = 4'd8;
    localparam logic [REG_W-1:0] REG_R9  = 4'd9;
    localparam logic [REG_W-1:0] REG_R10 = 4'd10;
    localparam logic [REG_W-1:0] REG_R11 = 4'd11;
    localparam logic [REG_W-1:0] REG_R12 = 4'd12;
    localparam logic [REG_W-1:0] REG_R13 = 4'd13;
    localparam logic [REG_W-1:0] REG_R14 = 4'd14;
    localparam logic [REG_W-1:0] REG_R15 = 4'd15;

    // One queued Execute result. res/dest is the primary write, resSpec/destS
    // the secondary one (e.g. the high half of a MUL going to RDX).
    typedef struct packed {
        logic [DATA_W-1:0] res;
        logic [DATA_W-1:0] resSpec;
        logic [REG_W-1:0]  dest;
        logic              destV;
        logic [REG_W-1:0]  destS;
        logic              destSV;
        logic [RIP_W-1:0]  rip;
        logic              kill;
    } wb_entry_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } wb_state_t;

endpackage

// File: rtl/regfile_2r2w.sv
// ---------------------------------------------------------------------------
// regfile_2r2w
// NREG x DATA_W register array with two write ports and two combinational,
// bypassed read ports. Cleared to zero by the asynchronous active-low reset.
//   clk, reset_n        clock / async active-low reset
//   we1, wa1, wd1       write port 1 (wins when both ports hit one register)
//   we2, wa2, wd2       write port 2
//   ra1, rd1            read port 1 address / data
//   ra2, rd2            read port 2 address / data
// A read whose address matches an enabled write port returns that write
// data in the same cycle, with port 1 taking priority over port 2.
// ---------------------------------------------------------------------------
module regfile_2r2w #(
    parameter  int DATA_W = 64,
    parameter  int NREG   = 16,
    localparam int AW     = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we1,
    input  logic [AW-1:0]     wa1,
    input  logic [DATA_W-1:0] wd1,
    input  logic              we2,
    input  logic [AW-1:0]     wa2,
    input  logic [DATA_W-1:0] wd2,
    input  logic [AW-1:0]     ra1,
    input  logic [AW-1:0]     ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2
);

    logic [DATA_W-1:0] regs [NREG];

    // Port 2 is assigned first so that port 1's later non-blocking write
    // lands on top of it when both target the same register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (we2) begin
                regs[wa2] <= wd2;
            end
            if (we1) begin
                regs[wa1] <= wd1;
            end
        end
    end

    // Bypassed reads: array value, overridden by port 2 then port 1 so the
    // priority matches the write side.
    always_comb begin
        rd1 = regs[ra1];
        if (we2 && (wa2 == ra1)) begin
            rd1 = wd2;
        end
        if (we1 && (wa1 == ra1)) begin
            rd1 = wd1;
        end
    end

    always_comb begin
        rd2 = regs[ra2];
        if (we2 && (wa2 == ra2)) begin
            rd2 = wd2;
        end
        if (we1 && (wa1 == ra2)) begin
            rd2 = wd1;
        end
    end

endmodule

// File: rtl/writeback_regfile.sv
// ---------------------------------------------------------------------------
// writeback_regfile
// Consumer end of the Execute result interface. Results are buffered in a
// small in-order queue and retired one per cycle into the architectural
// register file, which also serves the Decode operand-read ports.
//   clk, reset_n                      clock / async active-low reset
//   exValidIn, exReadyOut             Execute result handshake
//   aluResultIn, destRegIn,
//   destRegValidIn                    primary result and destination
//   aluResultSpecialIn,
//   destRegSpecialIn,
//   destRegSpecialValidIn             secondary result and destination
//   currentRipIn                      RIP of the producing instruction
//   killIn                            instruction terminates the program
//   wbStallIn                         hold retirement this cycle
//   rdReg1In/rdVal1Out,
//   rdReg2In/rdVal2Out                combinational bypassed reads
//   retireValidOut                    head entry retires this cycle
//   lastRipOut                        RIP of the most recent retire
//   retiredCountOut                   retired instruction count
//   haltedOut                         a kill entry has retired
// ---------------------------------------------------------------------------
module writeback_regfile
    import x86_regs_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              exValidIn,
    output logic              exReadyOut,
    input  logic [DATA_W-1:0] aluResultIn,
    input  logic [DATA_W-1:0] aluResultSpecialIn,
    input  logic [REG_W-1:0]  destRegIn,
    input  logic              destRegValidIn,
    input  logic [REG_W-1:0]  destRegSpecialIn,
    input  logic              destRegSpecialValidIn,
    input  logic [RIP_W-1:0]  currentRipIn,
    input  logic              killIn,
    input  logic              wbStallIn,
    input  logic [REG_W-1:0]  rdReg1In,
    input  logic [REG_W-1:0]  rdReg2In,
    output logic [DATA_W-1:0] rdVal1Out,
    output logic [DATA_W-1:0] rdVal2Out,
    output logic              retireValidOut,
    output logic [RIP_W-1:0]  lastRipOut,
    output logic [63:0]       retiredCountOut,
    output logic              haltedOut
);

    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNT_W = $clog2(QDEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(QDEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(QDEPTH - 1);

    wb_entry_t        queue [QDEPTH];
    wb_entry_t        newEntry;
    wb_entry_t        headEntry;
    logic [PTR_W-1:0] headPtr;
    logic [PTR_W-1:0] tailPtr;
    logic [CNT_W-1:0] count;
    wb_state_t        state;
    logic             killSeen;
    logic             push;
    logic             pop;

    assign newEntry = '{
        res:     aluResultIn,
        resSpec: aluResultSpecialIn,
        dest:    destRegIn,
        destV:   destRegValidIn,
        destS:   destRegSpecialIn,
        destSV:  destRegSpecialValidIn,
        rip:     currentRipIn,
        kill:    killIn
    };

    assign headEntry = queue[headPtr];

    // Once a kill has been accepted nothing younger may enter the queue.
    assign exReadyOut     = (count < CNT_FULL) && !killSeen && (state == RUN);
    assign push           = exValidIn && exReadyOut;
    assign pop            = (count != '0) && !wbStallIn && (state != HALT);
    assign retireValidOut = pop;
    assign haltedOut      = (state == HALT);

    // Queue payload storage; validity is tracked purely by the pointers and
    // count, so the payload itself needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            queue[tailPtr] <= newEntry;
        end
    end

    // Queue pointers and occupancy. A simultaneous push and pop leaves the
    // count unchanged.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            headPtr <= '0;
            tailPtr <= '0;
            count   <= '0;
        end else begin
            if (push) begin
                tailPtr <= (tailPtr == PTR_LAST) ? '0 : tailPtr + 1'b1;
            end
            if (pop) begin
                headPtr <= (headPtr == PTR_LAST) ? '0 : headPtr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Retirement FSM: accepting a kill moves to DRAIN, retiring it moves to
    // HALT, which only reset leaves.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= RUN;
            killSeen <= 1'b0;
        end else begin
            if (push && killIn) begin
                killSeen <= 1'b1;
            end
            case (state)
                RUN: begin
                    if (push && killIn) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && headEntry.kill) begin
                        state <= HALT;
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    // Retirement bookkeeping for the entry leaving the head of the queue.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lastRipOut      <= '0;
            retiredCountOut <= '0;
        end else if (pop) begin
            lastRipOut      <= headEntry.rip;
            retiredCountOut <= retiredCountOut + 64'd1;
        end
    end

    // The secondary destination sits on write port 1 so it wins when both
    // destinations name the same register.
    regfile_2r2w #(
        .DATA_W (DATA_W),
        .NREG   (NREG)
    ) uRegfile (
        .clk     (clk),
        .reset_n (reset_n),
        .we1     (pop && headEntry.destSV),
        .wa1     (headEntry.destS),
        .wd1     (headEntry.resSpec),
        .we2     (pop && headEntry.destV),
        .wa2     (headEntry.dest),
        .wd2     (headEntry.res),
        .ra1     (rdReg1In),
        .ra2     (rdReg2In),
        .rd1     (rdVal1Out),
        .rd2     (rdVal2Out)
    );

endmodule

// File: tb/tb_writeback_regfile.sv
// ---------------------------------------------------------------------------
// tb_writeback_regfile
// Directed bench for writeback_regfile: one task per scenario, inputs driven
// 1 time unit after the rising edge, outputs sampled shortly after that.
// ---------------------------------------------------------------------------
module tb_writeback_regfile;
    import x86_regs_pkg::*;

    logic              clk;
    logic              reset_n;
    logic              exValidIn;
    logic              exReadyOut;
    logic [DATA_W-1:0] aluResultIn;
    logic [DATA_W-1:0] aluResultSpecialIn;
    logic [REG_W-1:0]  destRegIn;
    logic              destRegValidIn;
    logic [REG_W-1:0]  destRegSpecialIn;
    logic              destRegSpecialValidIn;
    logic [RIP_W-1:0]  currentRipIn;
    logic              killIn;
    logic              wbStallIn;
    logic [REG_W-1:0]  rdReg1In;
    logic [REG_W-1:0]  rdReg2In;
    logic [DATA_W-1:0] rdVal1Out;
    logic [DATA_W-1:0] rdVal2Out;
    logic              retireValidOut;
    logic [RIP_W-1:0]  lastRipOut;
    logic [63:0]       retiredCountOut;
    logic              haltedOut;

    int checks = 0;
    int errors = 0;

    writeback_regfile dut (
        .clk                   (clk),
        .reset_n               (reset_n),
        .exValidIn             (exValidIn),
        .exReadyOut            (exReadyOut),
        .aluResultIn           (aluResultIn),
        .aluResultSpecialIn    (aluResultSpecialIn),
        .destRegIn             (destRegIn),
        .destRegValidIn        (destRegValidIn),
        .destRegSpecialIn      (destRegSpecialIn),
        .destRegSpecialValidIn (destRegSpecialValidIn),
        .currentRipIn          (currentRipIn),
        .killIn                (killIn),
        .wbStallIn             (wbStallIn),
        .rdReg1In              (rdReg1In),
        .rdReg2In              (rdReg2In),
        .rdVal1Out             (rdVal1Out),
        .rdVal2Out             (rdVal2Out),
        .retireValidOut        (retireValidOut),
        .lastRipOut            (lastRipOut),
        .retiredCountOut       (retiredCountOut),
        .haltedOut             (haltedOut)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one Execute result onto the input interface.
    task automatic applyStimulus(input logic v, input logic [63:0] res, input logic [63:0] resSpec,
                                 input logic [3:0] dest, input logic destV, input logic [3:0] destS,
                                 input logic destSV, input logic [31:0] rip, input logic kill);
        exValidIn             = v;
        aluResultIn           = res;
        aluResultSpecialIn    = resSpec;
        destRegIn             = dest;
        destRegValidIn        = destV;
        destRegSpecialIn      = destS;
        destRegSpecialValidIn = destSV;
        currentRipIn          = rip;
        killIn                = kill;
    endtask

    // Fill the queue under stall, start a retire, then reset before the edge.
    task automatic test_reset();
        wbStallIn = 1'b1;
        rdReg1In  = REG_RAX;
        applyStimulus(1'b1, 64'hAA, 64'h0, REG_RAX, 1'b1, REG_RAX, 1'b0, 32'h10, 1'b0);
        step();
        applyStimulus(1'b1, 64'hBB, 64'h0, REG_RAX, 1'b1, REG_RAX, 1'b0, 32'h14, 1'b0);
        step();
        exValidIn = 1'b0;
        #1;
        checks++;
        if (exReadyOut !== 1'b0) begin errors++; $display("[TB] FAIL reset_full_ready got %b want 0", exReadyOut); end
        wbStallIn = 1'b0;
        #1;
        checks++;
        if (retireValidOut !== 1'b1) begin errors++; $display("[TB] FAIL reset_pre_retire got %b want 1", retireValidOut); end
        reset_n = 1'b0;
        #1;
        checks++;
        if (retireValidOut !== 1'b0) begin errors++; $display("[TB] FAIL reset_low_retire got %b want 0", retireValidOut); end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        checks++;
        if (exReadyOut !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got %b want 1", exReadyOut); end
        checks++;
        if (rdVal1Out !== 64'h0) begin errors++; $display("[TB] FAIL reset_rax got %h want 0", rdVal1Out); end
        checks++;
        if (haltedOut !== 1'b0) begin errors++; $display("[TB] FAIL reset_halted got %b want 0", haltedOut); end
        checks++;
        if (retiredCountOut !== 64'd0) begin errors++; $display("[TB] FAIL reset_count got %0d want 0", retiredCountOut); end
        checks++;
        if (lastRipOut !== 32'h0) begin errors++; $display("[TB] FAIL reset_rip got %h want 0", lastRipOut); end
        step();
        checks++;
        if (retireValidOut !== 1'b0 || rdVal1Out !== 64'h0) begin
            errors++; $display("[TB] FAIL reset_empty retire=%b rax=%h want 0/0", retireValidOut, rdVal1Out);
        end
    endtask

    // Single result: visible through bypass the cycle after accept, then in the array.
    task automatic test_bypass();
        rdReg1In = REG_RBX;
        applyStimulus(1'b1, 64'h1234, 64'h0, REG_RBX, 1'b1, REG_RAX, 1'b0, 32'h100, 1'b0);
        #1;
        checks++;
        if (rdVal1Out !== 64'h0) begin errors++; $display("[TB] FAIL bypass_before got %h want 0", rdVal1Out); end
        step();
        exValidIn = 1'b0;
        #1;
        checks++;
        if (retireValidOut !== 1'b1) begin errors++; $display("[TB] FAIL bypass_retire got %b want 1", retireValidOut); end
        checks++;
        if (rdVal1Out !== 64'h1234) begin errors++; $display("[TB] FAIL bypass_val got %h want 1234", rdVal1Out); end
        step();
        checks++;
        if (rdVal1Out !== 64'h1234) begin errors++; $display("[TB] FAIL bypass_array got %h want 1234", rdVal1Out); end
        checks++;
        if (retiredCountOut !== 64'd1) begin errors++; $display("[TB] FAIL bypass_count got %0d want 1", retiredCountOut); end
        checks++;
        if (lastRipOut !== 32'h100) begin errors++; $display("[TB] FAIL bypass_rip got %h want 100", lastRipOut); end
        checks++;
        if (retireValidOut !== 1'b0) begin errors++; $display("[TB] FAIL bypass_idle got %b want 0", retireValidOut); end
    endtask

    // MUL writes RAX and RDX at the same edge.
    task automatic test_mul();
        rdReg1In = REG_RAX;
        rdReg2In = REG_RDX;
        applyStimulus(1'b1, 64'h5, 64'h7, REG_RAX, 1'b1, REG_RDX, 1'b1, 32'h104, 1'b0);
        step();
        exValidIn = 1'b0;
        #1;
        checks++;
        if (rdVal1Out !== 64'h5 || rdVal2Out !== 64'h7) begin
            errors++; $display("[TB] FAIL mul_bypass rax=%h rdx=%h want 5/7", rdVal1Out, rdVal2Out);
        end
        step();
        checks++;
        if (rdVal1Out !== 64'h5 || rdVal2Out !== 64'h7) begin
            errors++; $display("[TB] FAIL mul_array rax=%h rdx=%h want 5/7", rdVal1Out, rdVal2Out);
        end
        checks++;
        if (retiredCountOut !== 64'd2) begin errors++; $display("[TB] FAIL mul_count got %0d want 2", retiredCountOut); end
    endtask

    // Three results under stall: two accepted, third held; then in-order drain.
    task automatic test_back_to_back();
        wbStallIn = 1'b1;
        rdReg1In  = REG_RSI;
        rdReg2In  = REG_R8;
        applyStimulus(1'b1, 64'h11, 64'h0, REG_RSI, 1'b1, REG_RAX, 1'b0, 32'h200, 1'b0);
        #1;
        checks++;
        if (exReadyOut !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready0 got %b want 1", exReadyOut); end
        step();
        applyStimulus(1'b1, 64'h22, 64'h0, REG_RDI, 1'b1, REG_RAX, 1'b0, 32'h204, 1'b0);
        #1;
        checks++;
        if (exReadyOut !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready1 got %b want 1", exReadyOut); end
        step();
        applyStimulus(1'b1, 64'h33, 64'h0, REG_R8, 1'b1, REG_RAX, 1'b0, 32'h208, 1'b0);
        #1;
        checks++;
        if (exReadyOut !== 1'b0 || retireValidOut !== 1'b0) begin
            errors++; $display("[TB] FAIL b2b_full ready=%b retire=%b want 0/0", exReadyOut, retireValidOut);
        end
        step();
        checks++;
        if (exReadyOut !== 1'b0 || lastRipOut !== 32'h104) begin
            errors++; $display("[TB] FAIL b2b_held ready=%b rip=%h want 0/104", exReadyOut, lastRipOut);
        end
        wbStallIn = 1'b0;
        #1;
        checks++;
        if (retireValidOut !== 1'b1 || exReadyOut !== 1'b0) begin
            errors++; $display("[TB] FAIL b2b_release retire=%b ready=%b want 1/0", retireValidOut, exReadyOut);
        end
        step();
        checks++;
        if (lastRipOut !== 32'h200 || rdVal1Out !== 64'h11) begin
            errors++; $display("[TB] FAIL b2b_first rip=%h rsi=%h want 200/11", lastRipOut, rdVal1Out);
        end
        checks++;
        if (exReadyOut !== 1'b1 || retireValidOut !== 1'b1) begin
            errors++; $display("[TB] FAIL b2b_pushpop ready=%b retire=%b want 1/1", exReadyOut, retireValidOut);
        end
        step();
        exValidIn = 1'b0;
        #1;
        checks++;
        if (lastRipOut !== 32'h204 || retireValidOut !== 1'b1 || rdVal2Out !== 64'h33) begin
            errors++; $display("[TB] FAIL b2b_second rip=%h retire=%b r8=%h want 204/1/33", lastRipOut, retireValidOut, rdVal2Out);
        end
        step();
        rdReg1In = REG_RDI;
        #1;
        checks++;
        if (lastRipOut !== 32'h208 || retireValidOut !== 1'b0) begin
            errors++; $display("[TB] FAIL b2b_third rip=%h retire=%b want 208/0", lastRipOut, retireValidOut);
        end
        checks++;
        if (rdVal1Out !== 64'h22 || rdVal2Out !== 64'h33) begin
            errors++; $display("[TB] FAIL b2b_regs rdi=%h r8=%h want 22/33", rdVal1Out, rdVal2Out);
        end
        checks++;
        if (retiredCountOut !== 64'd5) begin errors++; $display("[TB] FAIL b2b_count got %0d want 5", retiredCountOut); end
    endtask

    // Both destinations name RCX: the special value must win.
    task automatic test_same_dest();
        rdReg1In = REG_RCX;
        applyStimulus(1'b1, 64'h1, 64'h2, REG_RCX, 1'b1, REG_RCX, 1'b1, 32'h300, 1'b0);
        step();
        exValidIn = 1'b0;
        #1;
        checks++;
        if (rdVal1Out !== 64'h2) begin errors++; $display("[TB] FAIL same_bypass got %h want 2", rdVal1Out); end
        step();
        checks++;
        if (rdVal1Out !== 64'h2) begin errors++; $display("[TB] FAIL same_array got %h want 2", rdVal1Out); end
        checks++;
        if (retiredCountOut !== 64'd6) begin errors++; $display("[TB] FAIL same_count got %0d want 6", retiredCountOut); end
    endtask

    // Kill entry followed by another result: second refused, sticky halt.
    task automatic test_kill();
        rdReg1In = REG_R9;
        rdReg2In = REG_R10;
        applyStimulus(1'b1, 64'h99, 64'h0, REG_R9, 1'b1, REG_RAX, 1'b0, 32'h400100, 1'b1);
        #1;
        checks++;
        if (exReadyOut !== 1'b1) begin errors++; $display("[TB] FAIL kill_accept got %b want 1", exReadyOut); end
        step();
        applyStimulus(1'b1, 64'hBAD, 64'h0, REG_R10, 1'b1, REG_RAX, 1'b0, 32'h500, 1'b0);
        #1;
        checks++;
        if (exReadyOut !== 1'b0) begin errors++; $display("[TB] FAIL kill_ready_drop got %b want 0", exReadyOut); end
        checks++;
        if (retireValidOut !== 1'b1 || haltedOut !== 1'b0) begin
            errors++; $display("[TB] FAIL kill_retiring retire=%b halted=%b want 1/0", retireValidOut, haltedOut);
        end
        step();
        checks++;
        if (haltedOut !== 1'b1) begin errors++; $display("[TB] FAIL kill_halted got %b want 1", haltedOut); end
        checks++;
        if (lastRipOut !== 32'h400100) begin errors++; $display("[TB] FAIL kill_rip got %h want 400100", lastRipOut); end
        checks++;
        if (retireValidOut !== 1'b0 || exReadyOut !== 1'b0) begin
            errors++; $display("[TB] FAIL kill_quiet retire=%b ready=%b want 0/0", retireValidOut, exReadyOut);
        end
        checks++;
        if (rdVal1Out !== 64'h99 || rdVal2Out !== 64'h0) begin
            errors++; $display("[TB] FAIL kill_regs r9=%h r10=%h want 99/0", rdVal1Out, rdVal2Out);
        end
        step();
        step();
        exValidIn = 1'b0;
        #1;
        checks++;
        if (retireValidOut !== 1'b0 || retiredCountOut !== 64'd7 || haltedOut !== 1'b1) begin
            errors++; $display("[TB] FAIL kill_sticky retire=%b count=%0d halted=%b want 0/7/1",
                               retireValidOut, retiredCountOut, haltedOut);
        end
        checks++;
        if (rdVal2Out !== 64'h0 || lastRipOut !== 32'h400100) begin
            errors++; $display("[TB] FAIL kill_no_late r10=%h rip=%h want 0/400100", rdVal2Out, lastRipOut);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        wbStallIn = 1'b0;
        rdReg1In  = REG_RAX;
        rdReg2In  = REG_RAX;
        applyStimulus(1'b0, 64'h0, 64'h0, REG_RAX, 1'b0, REG_RAX, 1'b0, 32'h0, 1'b0);
        step();
        step();
        reset_n = 1'b1;
        step();
        test_reset();
        test_bypass();
        test_mul();
        test_back_to_back();
        test_same_dest();
        test_kill();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
